ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_pkg.sv | 30 +++
 rtl/ifetch_bht.sv | 32 +++
 rtl/ifetch.sv | 122 ++++++++++++
 tb/tb_ifetch.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction fetch unit: FSM encodings, opcode
// constants and the BHT counter helpers.
package ifetch_pkg;

    localparam int ROB_WIDTH_BIT = 4;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        ISSUE     = 2'd1,
        JALR_WAIT = 2'd2
    } fetch_state_e;

    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [1:0] C_OP_Q2      = 2'b10;
    localparam logic [2:0] C_F3_JR_JALR = 3'b100;

    localparam logic [1:0] BHT_CNT_INIT = 2'b01;

    function automatic logic is_compressed(input logic [31:0] inst);
        return inst[1:0] != 2'b11;
    endfunction

    function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        else
            return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/ifetch_bht.sv
// Branch history table: 2-bit saturating counters with a combinational
// lookup that observes the pre-update value on a same-index collision.
module ifetch_bht
    import ifetch_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_i,
    input  logic [IDX_W-1:0] lookup_idx_i,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    output logic             taken_o
);

    localparam int N = 1 << IDX_W;

    logic [1:0] cnt_q [N];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < N; i++) cnt_q[i] <= BHT_CNT_INIT;
        end else if (en_i && upd_en_i) begin
            cnt_q[upd_idx_i] <= bht_next(cnt_q[upd_idx_i], upd_taken_i);
        end
    end

    assign taken_o = cnt_q[lookup_idx_i][1];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch FSM (FETCH -> ISSUE -> optional JALR_WAIT).
// Define IFETCH_BHT_EN to enable the dynamic branch predictor; otherwise static not-taken.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int          BHT_INDEX_BIT = 6,
    parameter logic [31:0] RESET_PC      = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_valid,
    input  logic [31:0] ic_data,
    output logic        to_decoder,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        predict,
    input  logic        dec_accept,
    input  logic [31:0] next_pc,
    input  logic        jalr_done,
    input  logic [31:0] jalr_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        br_commit,
    input  logic [31:0] br_pc,
    input  logic        br_taken
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic         pred_q, pred_d;
    logic         kill_q, kill_d;
    logic         bht_taken;

`ifdef IFETCH_BHT_EN
    ifetch_bht #(
        .IDX_W(BHT_INDEX_BIT)
    ) u_bht (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .en_i        (rdy_in),
        .lookup_idx_i(pc_q[BHT_INDEX_BIT:1]),
        .upd_en_i    (br_commit),
        .upd_idx_i   (br_pc[BHT_INDEX_BIT:1]),
        .upd_taken_i (br_taken),
        .taken_o     (bht_taken)
    );
`else
    logic unused_br;
    assign unused_br = ^{br_commit, br_pc, br_taken};
    assign bht_taken = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        pred_d  = pred_q;
        kill_d  = 1'b0;
        if (flush) begin
            // Restart wins over any same-cycle handshake; the kill flag drops the stale reply.
            state_d = FETCH;
            pc_d    = flush_pc;
            kill_d  = 1'b1;
        end else begin
            case (state_q)
                FETCH: begin
                    if (ic_valid && !kill_q) begin
                        inst_d  = ic_data;
                        pred_d  = bht_taken;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (dec_accept) begin
                        if (next_pc != pc_q) begin
                            pc_d    = next_pc;
                            state_d = FETCH;
                        end else begin
                            state_d = JALR_WAIT;
                        end
                    end
                end
                JALR_WAIT: begin
                    if (jalr_done) begin
                        pc_d    = {jalr_target[31:1], 1'b0};
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            pred_q  <= 1'b0;
            kill_q  <= 1'b1;
        end else if (rdy_in) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pred_q  <= pred_d;
            kill_q  <= kill_d;
        end
    end

    // Request is held off while reset is asserted so the cache sees it only after release.
    assign ic_req     = (state_q == FETCH) && !rst_in;
    assign ic_addr    = pc_q;
    assign to_decoder = (state_q == ISSUE);
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign predict    = pred_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: stimulus pushes expected decoder presentations
// into a queue, an independent monitor pops and compares them.
module tb_ifetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_data;
    logic        to_decoder;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        predict;
    logic        dec_accept;
    logic [31:0] next_pc;
    logic        jalr_done;
    logic [31:0] jalr_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic        br_commit;
    logic [31:0] br_pc;
    logic        br_taken;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

`ifdef IFETCH_BHT_EN
    localparam logic BHT_ON = 1'b1;
`else
    localparam logic BHT_ON = 1'b0;
`endif

    ifetch #(
        .BHT_INDEX_BIT(6),
        .RESET_PC     (32'h0)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .ic_req     (ic_req),
        .ic_addr    (ic_addr),
        .ic_valid   (ic_valid),
        .ic_data    (ic_data),
        .to_decoder (to_decoder),
        .pc         (pc),
        .inst       (inst),
        .predict    (predict),
        .dec_accept (dec_accept),
        .next_pc    (next_pc),
        .jalr_done  (jalr_done),
        .jalr_target(jalr_target),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .br_commit  (br_commit),
        .br_pc      (br_pc),
        .br_taken   (br_taken)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Monitor: each new decoder presentation must match the oldest expectation.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk_in);
            if (to_decoder === 1'b1 && prev !== 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_issue actual_pc=%h expected=none", pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_pc", pc, e.pc);
                    chk("mon_inst", inst, e.inst);
                    chk("mon_predict", {31'b0, predict}, {31'b0, e.pred});
                end
            end
            prev = to_decoder;
        end
    end

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input logic pred);
        int n;
        n = 0;
        while (ic_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("fetch_req", {31'b0, ic_req}, 32'd1);
        chk("fetch_addr", ic_addr, addr);
        exp_q.push_back('{pc: addr, inst: data, pred: pred});
        ic_valid = 1'b1;
        ic_data  = data;
        tick();
        ic_valid = 1'b0;
        ic_data  = 32'h0;
    endtask

    task automatic accept(input logic [31:0] npc);
        dec_accept = 1'b1;
        next_pc    = npc;
        tick();
        dec_accept = 1'b0;
        next_pc    = 32'h0;
    endtask

    task automatic commit(input logic [31:0] bpc, input logic tk);
        br_commit = 1'b1;
        br_pc     = bpc;
        br_taken  = tk;
        tick();
        br_commit = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        ic_valid = 1'b0; ic_data = 32'h0;
        dec_accept = 1'b0; next_pc = 32'h0;
        jalr_done = 1'b0; jalr_target = 32'h0;
        flush = 1'b0; flush_pc = 32'h0;
        br_commit = 1'b0; br_pc = 32'h0; br_taken = 1'b0;

        tick(); tick();
        chk("rst_ic_req", {31'b0, ic_req}, 32'd0);
        chk("rst_to_dec", {31'b0, to_decoder}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_predict", {31'b0, predict}, 32'd0);

        // Release reset; a reply in the first cycle belongs to an abandoned request.
        rst_in   = 1'b0;
        ic_valid = 1'b1;
        ic_data  = 32'hDEADBEEF;
        #1;
        chk("rel_ic_req", {31'b0, ic_req}, 32'd1);
        chk("rel_ic_addr", ic_addr, 32'h0);
        tick();
        ic_valid = 1'b0;
        chk("kill_rst_to_dec", {31'b0, to_decoder}, 32'd0);

        do_fetch(32'h0, 32'h00500093, 1'b0);
        chk("iss_to_dec", {31'b0, to_decoder}, 32'd1);
        chk("iss_ic_req", {31'b0, ic_req}, 32'd0);

        // Decoder stall holds outputs, including while rdy_in freezes an accept.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_to_dec", {31'b0, to_decoder}, 32'd1);
            chk("stall_pc", pc, 32'h0);
            chk("stall_inst", inst, 32'h00500093);
        end
        rdy_in = 1'b0;
        accept(32'h8);
        rdy_in = 1'b1;
        chk("frozen_to_dec", {31'b0, to_decoder}, 32'd1);
        chk("frozen_pc", pc, 32'h0);
        accept(32'h4);
        chk("acc_ic_req", {31'b0, ic_req}, 32'd1);
        chk("acc_ic_addr", ic_addr, 32'h4);

        do_fetch(32'h4, 32'h00000013, 1'b0);
        accept(32'h10);
        do_fetch(32'h10, 32'h000080E7, 1'b0);
        accept(32'h10);
        chk("jw_ic_req", {31'b0, ic_req}, 32'd0);
        chk("jw_to_dec", {31'b0, to_decoder}, 32'd0);
        tick();
        chk("jw_hold_req", {31'b0, ic_req}, 32'd0);
        jalr_done   = 1'b1;
        jalr_target = 32'h101;
        tick();
        jalr_done = 1'b0;
        chk("jalr_ic_req", {31'b0, ic_req}, 32'd1);
        chk("jalr_ic_addr", ic_addr, 32'h100);

        do_fetch(32'h100, 32'h00100113, 1'b0);
        flush      = 1'b1;
        flush_pc   = 32'h200;
        dec_accept = 1'b1;
        next_pc    = 32'h104;
        tick();
        flush = 1'b0; dec_accept = 1'b0;
        chk("flush_to_dec", {31'b0, to_decoder}, 32'd0);
        chk("flush_ic_addr", ic_addr, 32'h200);
        ic_valid = 1'b1;
        ic_data  = 32'hBAD0BAD0;
        tick();
        ic_valid = 1'b0;
        chk("stale_to_dec", {31'b0, to_decoder}, 32'd0);
        chk("stale_ic_addr", ic_addr, 32'h200);

        // Flush in FETCH discards a reply arriving in the same cycle.
        flush    = 1'b1;
        flush_pc = 32'h300;
        ic_valid = 1'b1;
        ic_data  = 32'hBAD1BAD1;
        tick();
        flush = 1'b0; ic_valid = 1'b0;
        chk("flushf_to_dec", {31'b0, to_decoder}, 32'd0);
        chk("flushf_ic_addr", ic_addr, 32'h300);
        tick();

        do_fetch(32'h300, 32'h00208193, 1'b0);
        accept(32'h22);
        chk("c_ic_addr", ic_addr, 32'h22);
        do_fetch(32'h22, 32'h00004501, 1'b0);

        accept(32'h40);
        commit(32'h40, 1'b1);
        commit(32'h40, 1'b1);
        do_fetch(32'h40, 32'h00208463, BHT_ON);
        accept(32'h44);
        commit(32'h40, 1'b0);
        commit(32'h40, 1'b0);
        do_fetch(32'h44, 32'h00000013, 1'b0);
        accept(32'h40);
        // Same-cycle update at the looked-up index: the lookup sees the old counter (01).
        br_commit = 1'b1; br_pc = 32'h40; br_taken = 1'b1;
        do_fetch(32'h40, 32'h00208463, 1'b0);
        br_commit = 1'b0;
        accept(32'h44);
        accept_after_fetch();

        tick(); tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Counter at 0x40 is now 10 after the colliding update, so it predicts taken.
    task automatic accept_after_fetch();
        do_fetch(32'h44, 32'h00000013, 1'b0);
        accept(32'h40);
        do_fetch(32'h40, 32'h00208463, BHT_ON);
    endtask

    initial begin
        #50000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
